life_step_engine: RTL and testbench



---
 rtl/life_step_engine.sv | 169 ++++++++++++++++
 tb/tb_life_step_engine.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_step_engine.sv
// Game-of-Life generation stepper: streams the current frame through a three-row
// window and writes the B3/S23 next generation (toroidal) into the next-frame buffer.
module life_step_engine #(
  parameter int unsigned ROWS         = 48,
  parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK = 9'b000001100
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] cell_rdata,
  output logic [6:0]  cell_address,
  output logic        cell_write,
  output logic [31:0] cell_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] generation
);

  typedef enum logic [2:0] {StIdle, StLoad, StWr0, StWr1, StRd0, StRd1, StDone} state_e;

  localparam logic [5:0] LastRow = 6'(ROWS - 1);
  localparam logic [5:0] WrapRow = 6'(ROWS - 2);

  state_e      r_state, w_state_d;
  logic [2:0]  r_load_cnt, w_load_cnt_d;
  logic [5:0]  r_y, w_y_d;
  logic [63:0] r_prev, r_cur, r_nxt;
  logic [63:0] w_prev_d, w_cur_d, w_nxt_d;
  logic [31:0] r_stage, w_stage_d;
  logic [15:0] r_gen, w_gen_d;
  logic [63:0] w_next_gen;
  logic [5:0]  w_rd_row;
  logic [5:0]  w_load_row;

  // Column index arithmetic is 6 bits wide, so x-1 / x+1 wrap around the torus for free.
  function automatic logic [3:0] nbr_count(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c, input logic [5:0] x);
    logic [5:0] xl;
    logic [5:0] xr;
    xl = x - 6'd1;
    xr = x + 6'd1;
    return 4'(a[xl]) + 4'(a[x]) + 4'(a[xr]) + 4'(b[xl]) + 4'(b[xr]) +
           4'(c[xl]) + 4'(c[x]) + 4'(c[xr]);
  endfunction

  always_comb begin
    w_next_gen = '0;
    for (int x = 0; x < 64; x++) begin
      w_next_gen[x] = r_cur[x] ? SURVIVE_MASK[nbr_count(r_prev, r_cur, r_nxt, 6'(x))]
                               : BIRTH_MASK[nbr_count(r_prev, r_cur, r_nxt, 6'(x))];
    end
  end

  // Row fetched ahead of the window: (y+2) mod ROWS, only used while y <= ROWS-2.
  always_comb begin
    if (r_y >= WrapRow) begin
      w_rd_row = r_y - WrapRow;
    end else begin
      w_rd_row = r_y + 6'd2;
    end
  end

  // Preload order: last row, row 0, row 1 (two halves each).
  always_comb begin
    case (r_load_cnt[2:1])
      2'd0:    w_load_row = LastRow;
      2'd1:    w_load_row = 6'd0;
      default: w_load_row = 6'd1;
    endcase
  end

  always_comb begin
    w_state_d    = r_state;
    w_load_cnt_d = r_load_cnt;
    w_y_d        = r_y;
    w_prev_d     = r_prev;
    w_cur_d      = r_cur;
    w_nxt_d      = r_nxt;
    w_stage_d    = r_stage;
    w_gen_d      = r_gen;
    cell_address = '0;
    cell_write   = 1'b0;
    cell_wdata   = '0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d    = StLoad;
          w_load_cnt_d = '0;
        end
      end
      StLoad: begin
        cell_address = {w_load_row, r_load_cnt[0]};
        case (r_load_cnt)
          3'd0:    w_prev_d[31:0]  = cell_rdata;
          3'd1:    w_prev_d[63:32] = cell_rdata;
          3'd2:    w_cur_d[31:0]   = cell_rdata;
          3'd3:    w_cur_d[63:32]  = cell_rdata;
          3'd4:    w_nxt_d[31:0]   = cell_rdata;
          default: w_nxt_d[63:32]  = cell_rdata;
        endcase
        if (r_load_cnt == 3'd5) begin
          w_state_d = StWr0;
          w_y_d     = '0;
        end else begin
          w_load_cnt_d = r_load_cnt + 3'd1;
        end
      end
      StWr0: begin
        cell_address = {r_y, 1'b0};
        cell_write   = 1'b1;
        cell_wdata   = w_next_gen[31:0];
        w_state_d    = StWr1;
      end
      StWr1: begin
        cell_address = {r_y, 1'b1};
        cell_write   = 1'b1;
        cell_wdata   = w_next_gen[63:32];
        w_state_d    = (r_y == LastRow) ? StDone : StRd0;
      end
      StRd0: begin
        cell_address = {w_rd_row, 1'b0};
        w_stage_d    = cell_rdata;
        w_state_d    = StRd1;
      end
      StRd1: begin
        cell_address = {w_rd_row, 1'b1};
        w_prev_d     = r_cur;
        w_cur_d      = r_nxt;
        w_nxt_d      = {cell_rdata, r_stage};
        w_y_d        = r_y + 6'd1;
        w_state_d    = StWr0;
      end
      StDone: begin
        done      = 1'b1;
        w_gen_d   = r_gen + 16'd1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_load_cnt <= '0;
      r_y        <= '0;
      r_prev     <= '0;
      r_cur      <= '0;
      r_nxt      <= '0;
      r_stage    <= '0;
      r_gen      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_load_cnt <= w_load_cnt_d;
      r_y        <= w_y_d;
      r_prev     <= w_prev_d;
      r_cur      <= w_cur_d;
      r_nxt      <= w_nxt_d;
      r_stage    <= w_stage_d;
      r_gen      <= w_gen_d;
    end
  end

  assign busy       = (r_state != StIdle);
  assign generation = r_gen;

endmodule

// File: tb/tb_life_step_engine.sv
// Directed bench for life_step_engine with a two-buffer cell-store model; the bench
// performs the frame flip between generations.
module tb_life_step_engine;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cell_rdata;
  logic [6:0]  cell_address;
  logic        cell_write;
  logic [31:0] cell_wdata;
  logic        busy;
  logic        done;
  logic [15:0] generation;

  logic [31:0] mem_cur [128];
  logic [31:0] mem_nxt [128];
  logic [31:0] exp_frame [96];
  int          wr_count [128];
  int          wr_total;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  assign cell_rdata = mem_cur[cell_address];

  life_step_engine dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .cell_rdata   (cell_rdata),
    .cell_address (cell_address),
    .cell_write   (cell_write),
    .cell_wdata   (cell_wdata),
    .busy         (busy),
    .done         (done),
    .generation   (generation)
  );

  // Capture this cycle's write, then advance to 1 time unit after the next rising edge.
  task automatic step_cycle();
    if (cell_write) begin
      mem_nxt[cell_address] = cell_wdata;
      wr_count[cell_address]++;
      wr_total++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_frames();
    for (int i = 0; i < 128; i++) mem_cur[i] = '0;
    for (int i = 0; i < 96; i++) exp_frame[i] = '0;
  endtask

  task automatic set_cell(input int x, input int y);
    mem_cur[y * 2 + x / 32][x % 32] = 1'b1;
  endtask

  task automatic set_exp(input int x, input int y);
    exp_frame[y * 2 + x / 32][x % 32] = 1'b1;
  endtask

  task automatic flip();
    for (int i = 0; i < 96; i++) mem_cur[i] = mem_nxt[i];
  endtask

  task automatic do_reset();
    start   = 1'b0;
    reset_n = 1'b0;
    step_cycle();
    step_cycle();
    reset_n = 1'b1;
    step_cycle();
  endtask

  // Pulse start, then follow the generation; extra start pulses at busy cycles ign1/ign2.
  task automatic run_gen(input int ign1, input int ign2, output int n_busy,
                         output int done_at, output bit timed_out);
    n_busy    = 0;
    done_at   = -1;
    timed_out = 1'b1;
    wr_total  = 0;
    for (int i = 0; i < 128; i++) begin
      wr_count[i] = 0;
      mem_nxt[i]  = 32'hdead_beef;
    end
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (busy) n_busy++;
      if (done) done_at = cyc;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      start = (cyc == ign1) || (cyc == ign2);
      step_cycle();
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (cell_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_write: got %b expected 0", cell_write);
    end
    n_checks++;
    if (cell_address !== 7'd0) begin
      n_fail++; $display("FAIL reset_addr: got %0d expected 0", cell_address);
    end
    n_checks++;
    if (cell_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_wdata: got %h expected 0", cell_wdata);
    end
    n_checks++;
    if (generation !== 16'd0) begin
      n_fail++; $display("FAIL reset_gen: got %0d expected 0", generation);
    end
  endtask

  task automatic test_blinker();
    int nb, da;
    bit tmo;
    clear_frames();
    set_cell(10, 5); set_cell(11, 5); set_cell(12, 5);
    set_exp(11, 4);  set_exp(11, 5);  set_exp(11, 6);
    run_gen(-1, -1, nb, da, tmo);
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL blinker_timeout: got %b expected 0", tmo); end
    n_checks++;
    if (nb != 197) begin n_fail++; $display("FAIL blinker_busy_cycles: got %0d expected 197", nb); end
    n_checks++;
    if (da != 197) begin n_fail++; $display("FAIL blinker_done_cycle: got %0d expected 197", da); end
    n_checks++;
    if (generation !== 16'd1) begin
      n_fail++; $display("FAIL blinker_gen: got %0d expected 1", generation);
    end
    for (int i = 0; i < 96; i++) begin
      n_checks++;
      if (mem_nxt[i] !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL blinker_word %0d: got %h expected %h", i, mem_nxt[i], exp_frame[i]);
      end
    end
    flip();
  endtask

  task automatic test_block_straddle();
    int nb, da;
    bit tmo;
    clear_frames();
    set_cell(31, 20); set_cell(32, 20); set_cell(31, 21); set_cell(32, 21);
    set_exp(31, 20);  set_exp(32, 20);  set_exp(31, 21);  set_exp(32, 21);
    run_gen(-1, -1, nb, da, tmo);
    n_checks++;
    if (nb != 197) begin n_fail++; $display("FAIL block_busy_cycles: got %0d expected 197", nb); end
    n_checks++;
    if (generation !== 16'd2) begin
      n_fail++; $display("FAIL block_gen: got %0d expected 2", generation);
    end
    for (int i = 0; i < 96; i++) begin
      n_checks++;
      if (mem_nxt[i] !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL block_word %0d: got %h expected %h", i, mem_nxt[i], exp_frame[i]);
      end
    end
    flip();
  endtask

  task automatic test_torus_corner();
    int nb, da;
    bit tmo;
    clear_frames();
    set_cell(63, 47); set_cell(0, 47); set_cell(63, 0); set_cell(0, 0);
    set_exp(63, 47);  set_exp(0, 47);  set_exp(63, 0);  set_exp(0, 0);
    run_gen(-1, -1, nb, da, tmo);
    n_checks++;
    if (generation !== 16'd3) begin
      n_fail++; $display("FAIL torus_gen: got %0d expected 3", generation);
    end
    for (int i = 0; i < 96; i++) begin
      n_checks++;
      if (mem_nxt[i] !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL torus_word %0d: got %h expected %h", i, mem_nxt[i], exp_frame[i]);
      end
    end
    flip();
  endtask

  // Runs on the torus block left in the current frame; extra starts must be dropped.
  task automatic test_start_ignored();
    int nb, da, bad;
    bit tmo;
    run_gen(5, 197, nb, da, tmo);
    n_checks++;
    if (nb != 197) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d expected 197", nb); end
    n_checks++;
    if (wr_total != 96) begin n_fail++; $display("FAIL ignore_writes: got %0d expected 96", wr_total); end
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (wr_count[i] != ((i < 96) ? 1 : 0)) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL ignore_addr_once: got %0d bad addresses expected 0", bad); end
    step_cycle();
    step_cycle();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_restart: got busy %b expected 0", busy); end
    n_checks++;
    if (generation !== 16'd4) begin
      n_fail++; $display("FAIL ignore_gen: got %0d expected 4", generation);
    end
    for (int i = 0; i < 96; i++) begin
      n_checks++;
      if (mem_nxt[i] !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL ignore_word %0d: got %h expected %h", i, mem_nxt[i], exp_frame[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int nb, da;
    bit tmo;
    do_reset();
    clear_frames();
    set_cell(10, 5); set_cell(11, 5); set_cell(12, 5);
    set_exp(11, 4);  set_exp(11, 5);  set_exp(11, 6);
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    for (int cyc = 1; cyc < 50; cyc++) step_cycle();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++;
    if (cell_write !== 1'b0) begin
      n_fail++; $display("FAIL abort_write: got %b expected 0", cell_write);
    end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
    n_checks++;
    if (generation !== 16'd0) begin
      n_fail++; $display("FAIL abort_gen: got %0d expected 0", generation);
    end
    step_cycle();
    reset_n = 1'b1;
    step_cycle();
    run_gen(-1, -1, nb, da, tmo);
    n_checks++;
    if (nb != 197) begin n_fail++; $display("FAIL abort_rerun_busy: got %0d expected 197", nb); end
    n_checks++;
    if (generation !== 16'd1) begin
      n_fail++; $display("FAIL abort_rerun_gen: got %0d expected 1", generation);
    end
    for (int i = 0; i < 96; i++) begin
      n_checks++;
      if (mem_nxt[i] !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL abort_word %0d: got %h expected %h", i, mem_nxt[i], exp_frame[i]);
      end
    end
  endtask

  // A glider moves (+1,+1) per 4 generations: 192 generations wrap the rows exactly
  // once and shift the columns by 48.
  task automatic test_glider();
    int nb, da, bad_runs;
    bit tmo;
    do_reset();
    clear_frames();
    set_cell(5, 4);  set_cell(6, 5);  set_cell(4, 6);  set_cell(5, 6);  set_cell(6, 6);
    set_exp(53, 4);  set_exp(54, 5);  set_exp(52, 6);  set_exp(53, 6);  set_exp(54, 6);
    bad_runs = 0;
    for (int g = 0; g < 192; g++) begin
      run_gen(-1, -1, nb, da, tmo);
      if (tmo || nb != 197 || da != 197) bad_runs++;
      flip();
    end
    n_checks++;
    if (bad_runs != 0) begin
      n_fail++; $display("FAIL glider_runs: got %0d bad generations expected 0", bad_runs);
    end
    n_checks++;
    if (generation !== 16'd192) begin
      n_fail++; $display("FAIL glider_gen: got %0d expected 192", generation);
    end
    for (int i = 0; i < 96; i++) begin
      n_checks++;
      if (mem_cur[i] !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL glider_word %0d: got %h expected %h", i, mem_cur[i], exp_frame[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem_cur[i]  = '0;
      mem_nxt[i]  = '0;
      wr_count[i] = 0;
    end
    wr_total = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_blinker();
    test_block_straddle();
    test_torus_corner();
    test_start_ignored();
    test_reset_mid_op();
    test_glider();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
